// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD pipeline stages.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } assembler_state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational legality check for one BCD digit; shared by the BCD stages.
module bcd_digit_check
   import bcd_pkg::*;
(
   input  bcd_digit_t DigitIn,
   output logic       IsBcd
);

   assign IsBcd = (DigitIn <= BCD_MAX);

endmodule

// File: rtl/bcd_pair_assembler.sv
// Collects two BCD digits over a valid/ready handshake and presents them as a held pair.
//
//   state | meaning
//   EMPTY | waiting for the first digit of a pair
//   HALF  | first digit held in first_q, waiting for the second
//   FULL  | pair presented on YT/YO, waiting for PairAck
module bcd_pair_assembler
   import bcd_pkg::*;
#(
   parameter bit TENS_FIRST = 1'b1
) (
   input  logic       Clock,
   input  logic       Reset_N,
   input  logic       Clear,
   input  logic [3:0] DigitIn,
   input  logic       DigitValid,
   output logic       DigitReady,
   output logic [3:0] YT,
   output logic [3:0] YO,
   output logic       PairValid,
   input  logic       PairAck,
   output logic       Error
);

   assembler_state_t state_q, state_d;
   bcd_digit_t       first_q, first_d;
   bcd_digit_t       yt_q, yt_d;
   bcd_digit_t       yo_q, yo_d;
   logic             pair_valid_q, pair_valid_d;
   logic             error_q, error_d;

   logic             digit_ready;
   logic             accept;
   logic             is_bcd;

   bcd_digit_check u_digit_check (
      .DigitIn (DigitIn),
      .IsBcd   (is_bcd)
   );

   always_comb begin
      state_d      = state_q;
      first_d      = first_q;
      yt_d         = yt_q;
      yo_d         = yo_q;
      pair_valid_d = pair_valid_q;
      error_d      = error_q;

      digit_ready  = (state_q != FULL) && !Clear;
      accept       = DigitValid && digit_ready;

      if (Clear) begin
         state_d      = EMPTY;
         first_d      = '0;
         yt_d         = '0;
         yo_d         = '0;
         pair_valid_d = 1'b0;
         error_d      = 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  if (is_bcd) begin
                     first_d = DigitIn;
                     state_d = HALF;
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            HALF: begin
               if (accept) begin
                  if (is_bcd) begin
                     if (TENS_FIRST) begin
                        yt_d = first_q;
                        yo_d = DigitIn;
                     end else begin
                        yt_d = DigitIn;
                        yo_d = first_q;
                     end
                     pair_valid_d = 1'b1;
                     state_d      = FULL;
                  end else begin
                     // an illegal second digit abandons the whole pair
                     error_d = 1'b1;
                     first_d = '0;
                     state_d = EMPTY;
                  end
               end
            end
            FULL: begin
               if (PairAck) begin
                  pair_valid_d = 1'b0;
                  state_d      = EMPTY;
               end
            end
            default: begin
               state_d      = EMPTY;
               pair_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q      <= EMPTY;
         first_q      <= '0;
         yt_q         <= '0;
         yo_q         <= '0;
         pair_valid_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         first_q      <= first_d;
         yt_q         <= yt_d;
         yo_q         <= yo_d;
         pair_valid_q <= pair_valid_d;
         error_q      <= error_d;
      end
   end

   assign DigitReady = digit_ready;
   assign YT         = yt_q;
   assign YO         = yo_q;
   assign PairValid  = pair_valid_q;
   assign Error      = error_q;

endmodule
